// File: rtl/ob_table_cnt_acc.sv
// ob_table_cnt_acc: count accumulator fed by an upstream CSA tree.
// Beats arrive as save/carry word pairs and are folded into a redundant
// accumulator with a 4:2 compressor, so there is no carry-propagate add per beat.
// After the last beat, the redundant pair is resolved by two half-width
// adds over two cycles. The count is then held until the consumer takes it.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_vld/in_rdy     beat handshake; in_sop/in_eop mark the first/last beat
//   in_s, in_c        save and carry words (carry already bit-aligned)
//   out_vld/out_rdy   result handshake
//   out_cnt           resolved count modulo 2^W
//   out_ovf           true sum reached or exceeded 2^W
module ob_table_cnt_acc #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_vld,
  input  logic         in_sop,
  input  logic         in_eop,
  input  logic [W-1:0] in_s,
  input  logic [W-1:0] in_c,
  output logic         in_rdy,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_cnt,
  output logic         out_ovf
);

  localparam int unsigned H = W / 2;

  typedef enum logic [2:0] {StIdle, StAcc, StResLo, StResHi, StOut} state_e;

  state_e state_q, state_d;

  logic [W-1:0] acc_s_q, acc_s_d;
  logic [W-1:0] acc_c_q, acc_c_d;
  logic         ovf_q, ovf_d;
  logic [H-1:0] res_lo_q, res_lo_d;
  logic         cy_q, cy_d;
  logic [W-1:0] out_cnt_q, out_cnt_d;
  logic         out_ovf_q, out_ovf_d;

  logic         beat_acc;
  logic [W-1:0] base_s, base_c;
  logic         base_ovf;
  logic [W-1:0] l1_s, l1_m, l1_c;
  logic [W-1:0] l2_s, l2_m, l2_c;
  logic [H:0]   lo_sum, hi_sum;

  // A beat is folded in only when it starts a count or continues one;
  // a non-sop beat in IDLE is consumed and dropped.
  assign beat_acc = in_vld && in_rdy && (in_sop || (state_q == StAcc));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_s_q   <= '0;
      acc_c_q   <= '0;
      ovf_q     <= 1'b0;
      res_lo_q  <= '0;
      cy_q      <= 1'b0;
      out_cnt_q <= '0;
      out_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_s_q   <= acc_s_d;
      acc_c_q   <= acc_c_d;
      ovf_q     <= ovf_d;
      res_lo_q  <= res_lo_d;
      cy_q      <= cy_d;
      out_cnt_q <= out_cnt_d;
      out_ovf_q <= out_ovf_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_vld && in_sop) state_d = in_eop ? StResLo : StAcc;
      end
      StAcc: begin
        if (in_vld && in_eop) state_d = StResLo;
      end
      StResLo: state_d = StResHi;
      StResHi: state_d = StOut;
      StOut: begin
        if (out_rdy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic.
  always_comb begin
    in_rdy  = 1'b0;
    out_vld = 1'b0;
    unique case (state_q)
      StIdle, StAcc: in_rdy = 1'b1;
      StOut:         out_vld = 1'b1;
      default: ;
    endcase
  end

  assign out_cnt = out_cnt_q;
  assign out_ovf = out_ovf_q;

  // Datapath: 4:2 compression as two 3:2 layers. Any carry out of the top
  // bit is worth 2^W, so it is folded into the sticky overflow flag.
  always_comb begin
    base_s   = in_sop ? '0 : acc_s_q;
    base_c   = in_sop ? '0 : acc_c_q;
    base_ovf = in_sop ? 1'b0 : ovf_q;

    l1_s = base_s ^ base_c ^ in_s;
    l1_m = (base_s & base_c) | (base_s & in_s) | (base_c & in_s);
    l1_c = {l1_m[W-2:0], 1'b0};

    l2_s = l1_s ^ l1_c ^ in_c;
    l2_m = (l1_s & l1_c) | (l1_s & in_c) | (l1_c & in_c);
    l2_c = {l2_m[W-2:0], 1'b0};

    lo_sum = {1'b0, acc_s_q[H-1:0]} + {1'b0, acc_c_q[H-1:0]};
    hi_sum = {1'b0, acc_s_q[W-1:H]} + {1'b0, acc_c_q[W-1:H]} + {{H{1'b0}}, cy_q};
  end

  // Datapath register updates.
  always_comb begin
    acc_s_d   = acc_s_q;
    acc_c_d   = acc_c_q;
    ovf_d     = ovf_q;
    res_lo_d  = res_lo_q;
    cy_d      = cy_q;
    out_cnt_d = out_cnt_q;
    out_ovf_d = out_ovf_q;

    if (beat_acc) begin
      acc_s_d = l2_s;
      acc_c_d = l2_c;
      ovf_d   = base_ovf | l1_m[W-1] | l2_m[W-1];
    end

    if (state_q == StResLo) begin
      res_lo_d = lo_sum[H-1:0];
      cy_d     = lo_sum[H];
    end

    if (state_q == StResHi) begin
      out_cnt_d = {hi_sum[H-1:0], res_lo_q};
      out_ovf_d = ovf_q | hi_sum[H];
      ovf_d     = ovf_q | hi_sum[H];
    end
  end

endmodule

// File: tb/tb_ob_table_cnt_acc.sv
// Bench for ob_table_cnt_acc at W=8: directed cases plus randomized counts,
// checked against an integer-sum reference model.
module tb_ob_table_cnt_acc;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_vld, in_sop, in_eop;
  logic [W-1:0] in_s, in_c;
  logic         in_rdy;
  logic         out_vld;
  logic         out_rdy;
  logic [W-1:0] out_cnt;
  logic         out_ovf;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // Reference model: exact integer sum of the open count.
  bit          m_active = 1'b0;
  int unsigned m_sum    = 0;

  always #5 clk = ~clk;

  ob_table_cnt_acc #(.W(W)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (in_vld),
    .in_sop  (in_sop),
    .in_eop  (in_eop),
    .in_s    (in_s),
    .in_c    (in_c),
    .in_rdy  (in_rdy),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .out_cnt (out_cnt),
    .out_ovf (out_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_active = 1'b0;
    check("rst_out_vld", {31'd0, out_vld}, 32'd0);
    check("rst_in_rdy", {31'd0, in_rdy}, 32'd1);
    check("rst_out_cnt", {24'd0, out_cnt}, 32'd0);
    check("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
  endtask

  // Result timing and hold under backpressure, then a single transfer.
  task automatic drain(input logic [W-1:0] e_cnt, input bit e_ovf, input int bp);
    @(negedge clk);
    check("lat1_out_vld", {31'd0, out_vld}, 32'd0);
    check("lat1_in_rdy", {31'd0, in_rdy}, 32'd0);
    @(negedge clk);
    check("lat2_out_vld", {31'd0, out_vld}, 32'd0);
    @(negedge clk);
    check("lat3_out_vld", {31'd0, out_vld}, 32'd1);
    check("out_cnt", {24'd0, out_cnt}, {24'd0, e_cnt});
    check("out_ovf", {31'd0, out_ovf}, {31'd0, e_ovf});
    check("out_in_rdy", {31'd0, in_rdy}, 32'd0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_out_vld", {31'd0, out_vld}, 32'd1);
      check("bp_out_cnt", {24'd0, out_cnt}, {24'd0, e_cnt});
      check("bp_out_ovf", {31'd0, out_ovf}, {31'd0, e_ovf});
      check("bp_in_rdy", {31'd0, in_rdy}, 32'd0);
    end
    @(negedge clk);
    out_rdy = 1'b1;
    @(posedge clk);
    #1;
    out_rdy = 1'b0;
    check("post_out_vld", {31'd0, out_vld}, 32'd0);
    check("post_in_rdy", {31'd0, in_rdy}, 32'd1);
    check("post_out_cnt_hold", {24'd0, out_cnt}, {24'd0, e_cnt});
  endtask

  // Presents one beat for one cycle (DUT is expected ready) and updates the model.
  task automatic beat(input bit sop, input bit eop, input logic [W-1:0] s,
                      input logic [W-1:0] c, input bit drain_en, input int bp);
    bit done;
    done = 1'b0;
    @(negedge clk);
    in_vld = 1'b1;
    in_sop = sop;
    in_eop = eop;
    in_s   = s;
    in_c   = c;
    check("beat_in_rdy", {31'd0, in_rdy}, 32'd1);
    @(posedge clk);
    #1;
    in_vld = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    if (sop) begin
      m_sum    = int'(s) + int'(c);
      m_active = 1'b1;
    end else if (m_active) begin
      m_sum = m_sum + int'(s) + int'(c);
    end
    if (eop && m_active) begin
      m_active = 1'b0;
      done     = 1'b1;
    end
    if (done && drain_en) drain(m_sum[W-1:0], m_sum >= (1 << W), bp);
  endtask

  initial begin
    rst = 1'b1;
    in_vld = 1'b0;
    in_sop = 1'b0;
    in_eop = 1'b0;
    in_s = '0;
    in_c = '0;
    out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("init_out_vld", {31'd0, out_vld}, 32'd0);
    check("init_in_rdy", {31'd0, in_rdy}, 32'd1);
    check("init_out_cnt", {24'd0, out_cnt}, 32'd0);

    // Single beat.
    beat(1, 1, 8'h05, 8'h0A, 1, 0);
    // Multi-beat.
    beat(1, 0, 8'h10, 8'h01, 1, 0);
    beat(0, 0, 8'h20, 8'h02, 1, 0);
    beat(0, 1, 8'h30, 8'h03, 1, 0);
    // Overflow, then sop clears it.
    beat(1, 0, 8'hFF, 8'h00, 1, 0);
    beat(0, 1, 8'h02, 8'h00, 1, 0);
    beat(1, 1, 8'h01, 8'h00, 1, 0);
    // Backpressure.
    beat(1, 1, 8'h33, 8'h44, 1, 10);
    // Drop in IDLE, then restart mid-count.
    beat(0, 0, 8'h55, 8'h55, 1, 0);
    beat(0, 1, 8'h66, 8'h11, 1, 0);
    beat(1, 0, 8'h07, 8'h00, 1, 0);
    beat(1, 1, 8'h03, 8'h00, 1, 0);
    // Reset in ACC.
    beat(1, 0, 8'h09, 8'h01, 1, 0);
    beat(0, 0, 8'h04, 8'h04, 1, 0);
    do_reset();
    repeat (4) begin
      @(negedge clk);
      check("abandon_acc_out_vld", {31'd0, out_vld}, 32'd0);
    end
    beat(1, 1, 8'h02, 8'h02, 1, 0);
    // Reset mid-resolve and while holding a result.
    beat(1, 1, 8'hAA, 8'h0B, 0, 0);
    do_reset();
    @(negedge clk);
    check("abandon_res_out_vld", {31'd0, out_vld}, 32'd0);
    beat(1, 1, 8'hC0, 8'h0C, 0, 0);
    repeat (3) @(negedge clk);
    check("pending_out_vld", {31'd0, out_vld}, 32'd1);
    do_reset();
    @(negedge clk);
    check("abandon_out_vld", {31'd0, out_vld}, 32'd0);

    // Randomized counts.
    for (int n = 0; n < 60; n++) begin
      int nb;
      if ($urandom_range(0, 4) == 0)
        beat(0, $urandom_range(0, 1) != 0, W'($urandom), W'($urandom), 1, 0);
      nb = $urandom_range(1, 5);
      for (int b = 0; b < nb; b++) begin
        bit sop;
        sop = (b == 0) || ($urandom_range(0, 7) == 0);
        beat(sop, b == nb - 1, W'($urandom), W'($urandom), 1, $urandom_range(0, 4));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ob_table_cnt_acc.md
OB_TABLE_CNT_ACC -- requirements
Module: ob_table_cnt_acc

Interface
REQ-001 SHALL have parameter W, default 32: width of the count and of each carry-save input word; even and at least 4.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port in_vld, input, 1: carry-save beat valid.
REQ-005 SHALL have port in_sop, input, 1: first beat of a count.
REQ-006 SHALL have port in_eop, input, 1: last beat of a count; may coincide with in_sop.
REQ-007 SHALL have port in_s, input, W: save word from the upstream CSA tree.
REQ-008 SHALL have port in_c, input, W: carry word from the upstream CSA tree, already bit-aligned.
REQ-009 SHALL have port in_rdy, output, 1: beat accepted when in_vld & in_rdy.
REQ-010 SHALL have port out_vld, output, 1: resolved count valid.
REQ-011 SHALL have port out_rdy, input, 1: consumer accepts when out_vld & out_rdy.
REQ-012 SHALL have port out_cnt, output, W: resolved count, modulo 2^W.
REQ-013 SHALL have port out_ovf, output, 1: true sum of the count reached or exceeded 2^W.

Function
REQ-014 SHALL implement FSM states IDLE, ACC, RES_LO, RES_HI, OUT.
REQ-015 SHALL hold accumulator pair acc_s/acc_c (W bits each) plus a sticky ovf bit.
REQ-016 SHALL drive in_rdy=1 in IDLE and ACC only, and 0 in RES_LO, RES_HI and OUT.
REQ-017 SHALL, on an accepted beat, compress {acc_s, acc_c, in_s, in_c} with two 3:2 layers (4:2) into the new acc_s/acc_c, with no carry-propagate add in this path.
REQ-018 SHALL, on an accepted beat with in_sop=1 and in any state that accepts beats, use zero for acc_s, acc_c and ovf before compression; sop while in ACC discards the partial count.
REQ-019 SHALL set ovf whenever any 3:2 layer produces a carry out of bit W-1; ovf is cleared only by sop or reset.
REQ-020 SHALL, in IDLE, drop any accepted beat with in_sop=0 (consumed, state unchanged).
REQ-021 SHALL transition IDLE->ACC on an accepted sop beat without eop.
REQ-022 SHALL transition ->RES_LO on any accepted beat with in_eop=1 (sop&eop from IDLE, or eop in ACC).
REQ-023 SHALL, in RES_LO, add the low W/2 bits of acc_s and acc_c, register the low result and carry, then go to RES_HI.
REQ-024 SHALL, in RES_HI, add the high halves plus the registered carry, OR the final carry-out into ovf, then go to OUT.
REQ-025 SHALL latency: eop accepted at edge T -> out_vld=1 from the cycle after edge T+2 (3 edges).
REQ-026 SHALL, in OUT, hold out_vld=1 with out_cnt and out_ovf stable until out_rdy=1; on acceptance go to IDLE.
REQ-027 SHALL drive out_vld=0 outside OUT; out_cnt and out_ovf hold their last value outside OUT.
REQ-028 SHALL never lose or duplicate a result under out_rdy backpressure of any length.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, enter IDLE and clear acc_s, acc_c, ovf, out_cnt and out_ovf to 0.
REQ-030 SHALL, as a consequence, reset with out_vld=0 and in_rdy=1 on the first cycle after reset.
REQ-031 SHALL, on reset in any state (mid-accumulation, mid-resolve, or OUT with a pending result), abandon the in-flight count with no output produced.
REQ-032 SHALL let rst take priority over a simultaneous input or output handshake.

Verification (W=8)
REQ-033 SHALL pass the single-beat case: sop=eop=1, s=0x05, c=0x0A -> after 3 edges out_vld=1, out_cnt=0x0F, out_ovf=0; in_rdy=0 until accepted.
REQ-034 SHALL pass the multi-beat case: beats (s,c)=(0x10,0x01),(0x20,0x02),(0x30,0x03) with sop on the first and eop on the last -> out_cnt=0x66, out_ovf=0.
REQ-035 SHALL pass the overflow case: two beats (0xFF,0x00),(0x02,0x00) -> out_cnt=0x01, out_ovf=1; next single-beat count (0x01,0x00) -> out_ovf=0.
REQ-036 SHALL pass the backpressure case: out_rdy=0 for 10 cycles -> out_vld, out_cnt and out_ovf stable, in_rdy=0 throughout; out_rdy=1 -> one transfer, then IDLE with in_rdy=1.
REQ-037 SHALL pass the restart/drop case: non-sop beat in IDLE is ignored; sop (0x07,0) then sop+eop (0x03,0) -> out_cnt=0x03.
REQ-038 SHALL pass the reset-in-ACC case: rst asserted after two beats of a count -> no out_vld; a following single-beat count (0x02,0x02) -> out_cnt=0x04.
